// File: rtl/RS5_pkg.sv
// RS5_pkg: shared fetch-aligner types, FIFO depth and RV32 major opcodes
package RS5_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_aligner_state_e;
  localparam int FIFO_DEPTH = 4;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
endpackage

// File: rtl/decompresser.sv
// decompresser: expands an RV32C halfword into its 32-bit equivalent, 0 when illegal
module decompresser import RS5_pkg::*; (
  input  logic [15:0] c,
  output logic [31:0] instr
);
  logic [4:0] rd, rs2, rdp, rs1p;
  logic [11:0] imm6;
  logic [2:0] alu_f3;
  assign rd = c[11:7];
  assign rs2 = c[6:2];
  assign rdp = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign imm6 = {{7{c[12]}}, c[6:2]};
  assign alu_f3 = c[6:5] == 2'b00 ? 3'b000 : c[6:5] == 2'b01 ? 3'b100 : c[6:5] == 2'b10 ? 3'b110 : 3'b111;
  always_comb begin
    instr = '0;
    case ({c[15:13], c[1:0]})
      5'b000_00: instr = c[12:5] != 8'd0 ? {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OPC_OP_IMM} : '0;
      5'b010_00: instr = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OPC_LOAD};
      5'b110_00: instr = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, OPC_STORE};
      5'b000_01: instr = {imm6, rd, 3'b000, rd, OPC_OP_IMM};
      5'b001_01, 5'b101_01: instr = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}}, 4'b0, ~c[15], OPC_JAL};
      5'b010_01: instr = {imm6, 5'd0, 3'b000, rd, OPC_OP_IMM};
      5'b011_01: instr = {c[12], c[6:2]} == 6'd0 ? '0
                       : rd == 5'd2 ? {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, OPC_OP_IMM}
                       : {{15{c[12]}}, c[6:2], rd, OPC_LUI};
      5'b100_01: instr = c[11:10] == 2'b10 ? {imm6, rs1p, 3'b111, rs1p, OPC_OP_IMM}
                       : c[12] ? '0
                       : c[11:10] == 2'b00 ? {7'b0, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM}
                       : c[11:10] == 2'b01 ? {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM}
                       : {c[6:5] == 2'b00 ? 7'b0100000 : 7'b0, rdp, rs1p, alu_f3, rs1p, OPC_OP};
      5'b110_01, 5'b111_01: instr = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13], c[11:10], c[4:3], c[12], OPC_BRANCH};
      5'b000_10: instr = !c[12] ? {7'b0, c[6:2], rd, 3'b001, rd, OPC_OP_IMM} : '0;
      5'b010_10: instr = rd != 5'd0 ? {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OPC_LOAD} : '0;
      5'b100_10: instr = !c[12] ? (rs2 == 5'd0 ? (rd != 5'd0 ? {12'b0, rd, 3'b000, 5'd0, OPC_JALR} : '0) : {7'b0, rs2, 5'd0, 3'b000, rd, OPC_OP})
                       : (rs2 == 5'd0 ? (rd == 5'd0 ? 32'h00100073 : {12'b0, rd, 3'b000, 5'd1, OPC_JALR}) : {7'b0, rs2, rd, 3'b000, rd, OPC_OP});
      5'b110_10: instr = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, OPC_STORE};
      default: instr = '0;
    endcase
  end
endmodule

// File: rtl/fetch_aligner.sv
// fetch_aligner: word fetch into a halfword FIFO, emitting aligned 32-bit instructions
// COMPRESSED_EN: enables RVC decompression and halfword-granular PC alignment
module fetch_aligner import RS5_pkg::*; #(
  parameter logic [31:0] RESET_ADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o
);
  fetch_aligner_state_e state;
  logic [15:0] q [FIFO_DEPTH];
  logic [15:0] nq [FIFO_DEPTH];
  logic [2:0] count, pop_n, push_n, base;
  logic [31:0] pc, faddr, jpc;
  logic skip, jskip, is_c, valid, hs, push, req_ok, unused_bits;
`ifdef COMPRESSED_EN
  localparam logic RESET_SKIP = RESET_ADDR[1];
  logic [31:0] dec;
  decompresser u_dec (.c(q[0]), .instr(dec));
  assign is_c = q[0][1:0] != 2'b11;
  assign valid = (count >= 3'd1 && is_c) || count >= 3'd2;
  assign instr_o = valid ? (is_c ? dec : {q[1], q[0]}) : '0;
  assign instr_compressed_o = valid & is_c;
  assign jpc = {jump_target_i[31:1], 1'b0};
  assign jskip = jump_target_i[1];
`else
  localparam logic RESET_SKIP = 1'b0;
  assign is_c = 1'b0;
  assign valid = count >= 3'd2;
  assign instr_o = valid ? {q[1], q[0]} : '0;
  assign instr_compressed_o = 1'b0;
  assign jpc = {jump_target_i[31:2], 2'b00};
  assign jskip = 1'b0;
`endif
  assign unused_bits = ^jump_target_i[1:0];
  assign req_ok = state == IDLE && count <= 3'd2;
  assign mem_req_o = req_ok & ~jump_i & ~reset;
  assign mem_addr_o = faddr;
  assign instr_valid_o = valid;
  assign instr_pc_o = pc;
  assign hs = valid & instr_ready_i & ~jump_i;
  assign push = state == WAIT && mem_rvalid_i && !jump_i;
  assign pop_n = hs ? (is_c ? 3'd1 : 3'd2) : 3'd0;
  assign push_n = push ? (skip ? 3'd1 : 3'd2) : 3'd0;
  assign base = count - pop_n;
  // shift out popped halfwords, then append the response behind what remains
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      nq[i] = 3'(i) + pop_n < 3'(FIFO_DEPTH) ? q[2'(3'(i) + pop_n)] : 16'h0;
      if (push && 3'(i) == base) nq[i] = skip ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      if (push && !skip && 3'(i) == base + 3'd1) nq[i] = mem_rdata_i[31:16];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pc <= RESET_ADDR;
      faddr <= {RESET_ADDR[31:2], 2'b00};
      skip <= RESET_SKIP;
      for (int i = 0; i < FIFO_DEPTH; i++) q[i] <= '0;
    end else if (jump_i) begin
      state <= state != IDLE && !mem_rvalid_i ? DROP : IDLE;
      count <= '0;
      pc <= jpc;
      faddr <= {jump_target_i[31:2], 2'b00};
      skip <= jskip;
    end else begin
      state <= req_ok ? WAIT : state != IDLE && mem_rvalid_i ? IDLE : state;
      q <= nq;
      count <= count - pop_n + push_n;
      pc <= pc + {28'd0, pop_n, 1'b0};
      faddr <= faddr + (req_ok ? 32'd4 : 32'd0);
      skip <= skip & ~push;
    end
  end
endmodule

// File: tb/tb_fetch_aligner.sv
// tb_fetch_aligner: directed scoreboard bench with a single-outstanding memory responder
module tb_fetch_aligner;
  logic clk = 0, reset = 1, jump_i = 0, mem_rvalid_i = 0, instr_ready_i = 0;
  logic [31:0] jump_target_i = '0, mem_rdata_i = '0;
  logic mem_req_o, instr_valid_o, instr_compressed_o;
  logic [31:0] mem_addr_o, instr_o, instr_pc_o;

  fetch_aligner #(.RESET_ADDR(32'h100)) dut (
    .clk(clk), .reset(reset), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_compressed_o(instr_compressed_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        c;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mem [logic [31:0]];
  int errors = 0, checks = 0, reqs = 0, lat = 1, pcnt = 0, r0;
  bit pend = 0, want_rdy = 1, rst_v = 1, last_req = 0;
  logic [31:0] paddr = '0, last_addr = '0;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'h00A00513 + ((a - 32'h100) << 18);
  endfunction

  function automatic void push_exp(input logic [31:0] i, input logic [31:0] p, input logic c);
    exp_t e;
    e.instr = i;
    e.pc = p;
    e.c = c;
    sb.push_back(e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // drive inputs for the coming edge, then observe what that edge will commit
  task automatic tick(input bit j = 0, input logic [31:0] tgt = '0, input bit frdy = 0);
    exp_t e;
    @(negedge clk);
    reset = rst_v;
    jump_i = j;
    jump_target_i = tgt;
    instr_ready_i = frdy | (want_rdy && sb.size() != 0);
    mem_rvalid_i = 0;
    if (pend) begin
      if (pcnt == 0) begin
        mem_rvalid_i = 1;
        mem_rdata_i = rd_mem(paddr);
        pend = 0;
      end else pcnt--;
    end
    #1;
    last_req = mem_req_o;
    last_addr = mem_addr_o;
    if (mem_req_o) begin
      reqs++;
      chk("single_outstanding", 32'(pend), 0);
      chk("addr_aligned", 32'(mem_addr_o[1:0]), 0);
      pend = 1;
      paddr = mem_addr_o;
      pcnt = lat - 1;
    end
    if (instr_valid_o && instr_ready_i && !jump_i) begin
      if (sb.size() == 0) chk("unexpected_instr_pc", instr_pc_o, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("instr", instr_o, e.instr);
        chk("pc", instr_pc_o, e.pc);
        chk("compressed", 32'(instr_compressed_o), 32'(e.c));
      end
    end
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_done", sb.size(), 0);
  endtask

  task automatic wait_req(input int bound);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last_req && n < bound);
    chk("req_seen", 32'(last_req), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 'h100; a < 'h200; a += 4) mem[a] = w(a);
    mem[32'h204] = 32'h4505_0001;
    mem[32'h0] = 32'h4501_4505;

    repeat (3) begin
      tick();
      chk("rst_req", 32'(mem_req_o), 0);
      chk("rst_valid", 32'(instr_valid_o), 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_compressed", 32'(instr_compressed_o), 0);
    end
    rst_v = 0;
    tick();
    chk("first_req", 32'(last_req), 1);
    chk("first_addr", last_addr, 32'h100);

    push_exp(32'h00A00513, 32'h100, 0);
    push_exp(w(32'h104), 32'h104, 0);
    push_exp(w(32'h108), 32'h108, 0);
    drain(60);

    // decode stalled: buffer must fill and stop requesting
    repeat (8) tick();
    r0 = reqs;
    repeat (8) tick();
    chk("bp_no_req", reqs - r0, 0);
    chk("bp_valid", 32'(instr_valid_o), 1);
    for (int a = 'h10C; a <= 'h118; a += 4) push_exp(w(a), a, 0);
    drain(60);

    tick(1, 32'h180, 1);
    tick();
    chk("jump_hs_valid", 32'(instr_valid_o), 0);
    chk("jump_hs_pc", instr_pc_o, 32'h180);
    push_exp(w(32'h180), 32'h180, 0);
    push_exp(w(32'h184), 32'h184, 0);
    drain(60);

    lat = 4;
    tick(1, 32'h1C0);
    wait_req(20);
    tick(1, 32'h206);
    wait_req(20);
    chk("jump_fetch_addr", last_addr, 32'h204);
`ifdef COMPRESSED_EN
    push_exp(32'h00100513, 32'h206, 1);
`else
    push_exp(32'h45050001, 32'h204, 0);
`endif
    drain(60);
    lat = 1;

`ifdef COMPRESSED_EN
    tick(1, 32'h0);
    push_exp(32'h00100513, 32'h0, 1);
    push_exp(32'h00000513, 32'h2, 1);
    drain(60);
    mem[32'h0] = 32'h0513_4505;
    mem[32'h4] = 32'h4501_00A0;
    tick(1, 32'h0);
    push_exp(32'h00100513, 32'h0, 1);
    push_exp(32'h00A00513, 32'h2, 0);
    push_exp(32'h00000513, 32'h6, 1);
    drain(60);
`else
    tick(1, 32'h0);
    push_exp(32'h45014505, 32'h0, 0);
    drain(60);
    tick(1, 32'h2);
    push_exp(32'h45014505, 32'h0, 0);
    drain(60);
`endif

    // reset while a fetch is outstanding; its response lands during reset
    lat = 3;
    tick(1, 32'h1C0);
    wait_req(20);
    rst_v = 1;
    repeat (4) tick();
    chk("midrst_valid", 32'(instr_valid_o), 0);
    chk("midrst_pc", instr_pc_o, 32'h100);
    pend = 0;
    lat = 1;
    rst_v = 0;
    push_exp(w(32'h100), 32'h100, 0);
    push_exp(w(32'h104), 32'h104, 0);
    drain(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
